instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the RV32I control unit and datapath. Owns the PC.
//  Issues one instruction-memory read per instruction and holds the fetched word stable
//  until the core retires it. On retire, it selects the next PC from pc_src, using the
//  same encoding the control unit drives. Exposes opcode[6:0] directly to the control unit.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; first fetch address
// PORTS
//  clk            in   1   core clock; all state updates on rising edge
//  rst_n          in   1   synchronous, active-low reset
//  imem_req       out  1   read request to instruction memory (one-cycle pulse)
//  imem_addr      out  32  read address, equals pc
//  imem_rvalid    in   1   instruction memory read data valid
//  imem_rdata     in   32  instruction word
//  instr_valid    out  1   instr/pc/opcode valid, held until retire
//  instr          out  32  latched instruction word
//  opcode         out  7   instr[6:0], feeds the control unit
//  pc             out  32  address of instr
//  pc_plus4       out  32  pc + 4, modulo 2^32 (writeback source for jal/jalr)
//  retire         in   1   core has finished instr; next-PC inputs valid this cycle
//  pc_src         in   2   00 pc+4, 01 branch, 10 jal, 11 jalr
//  branch_taken   in   1   branch condition result; only used when pc_src=01
//  branch_target  in   32  pc + B-immediate
//  jal_target     in   32  pc + J-immediate
//  jalr_target    in   32  rs1 + I-immediate (raw, unmasked)
//  fetch_fault    out  1   sticky: next PC was misaligned; fetch halted
//  retired_count  out  32  number of retired instructions, wraps at 2^32
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=RST, pc=RESET_PC, instr=32'h0000_0013 (NOP),
//   instr_valid=0, imem_req=0, fetch_fault=0, retired_count=0.
//  FSM states: RST, FETCH, WAIT, EXEC, FAULT.
//   RST   -> FETCH unconditionally; first imem_req occurs 1 cycle after reset release.
//   FETCH -> imem_req=1, imem_addr=pc for exactly 1 cycle; next state WAIT.
//   WAIT  -> imem_req=0; on imem_rvalid=1: instr<=imem_rdata; next state EXEC.
//            Stays in WAIT indefinitely with no timeout.
//   EXEC  -> instr_valid=1. On retire=1: compute next_pc, retired_count+=1.
//            If next_pc[1]=1, go to FAULT with pc unchanged.
//            Else pc<=next_pc and go to FETCH.
//   FAULT -> fetch_fault=1, instr_valid=0, imem_req=0; exits only on reset.
//  next_pc:
//   00 -> pc+4; 01 -> branch_taken ? branch_target : pc+4; 10 -> jal_target;
//   11 -> {jalr_target[31:1],1'b0} (bit0 cleared per RV32I).
//  All adds are 32-bit unsigned and drop the carry; pc=32'hFFFF_FFFC with pc+4 gives 0.
//  Fault check (next_pc[1]) is applied after jalr masking; an instr-aligned pc+4 never faults.
//  Ignored inputs:
//   imem_rvalid outside WAIT is ignored; at most one request is outstanding.
//   retire outside EXEC is ignored; pc_src/targets are sampled only when retire=1 in EXEC.
//  Minimum instruction period is 3 cycles (FETCH, WAIT with same-cycle rvalid, EXEC).
//  opcode = instr[6:0] combinationally; pc_plus4 = pc + 4 combinationally.
//  Outputs are stable for the whole EXEC state.
//  Reset mid-operation (any state) aborts immediately to reset values.
//   Instruction memory shares rst_n, so no stale response crosses reset.
//  Simultaneous rst_n=0 and retire=1: reset wins; the retire is not counted.
// TESTING
//  1 Reset release, RESET_PC=0, rvalid 1 cycle after req, rdata=32'h00500093
//    -> imem_req pulse at addr 0; instr_valid=1; opcode=7'h13; pc_plus4=4.
//  2 Retire with pc_src=01, branch_taken=0, branch_target=0x40 -> next fetch at 0x4.
//    Repeat with branch_taken=1 -> next fetch at 0x40; retired_count=2.
//  3 pc_src=11, jalr_target=0x0000_0103 -> next imem_addr=0x102, fetch_fault=1?
//    No: 0x102[1]=1 -> FAULT, fetch_fault=1, no further imem_req.
//    Also jalr_target=0x0000_0201 -> fetch at 0x200.
//  4 pc=0xFFFF_FFFC, pc_src=00, retire -> next imem_addr=0x0000_0000.
//  5 Hold imem_rvalid=0 for 10 cycles in WAIT, pulse rvalid in EXEC, assert retire in WAIT
//    -> no state change, no extra instr capture, retired_count unchanged.
//  6 rst_n=0 for 1 cycle during WAIT, and also coincident with retire in EXEC
//    -> all outputs return to reset values; next req at RESET_PC; count not incremented.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - RV32I fetch stage: owns the PC, fetches one word per instruction, holds it until retire
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        retire,
   input  logic [1:0]  pc_src,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] jal_target,
   input  logic [31:0] jalr_target,
   output logic        fetch_fault,
   output logic [31:0] retired_count
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_EXEC  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] count_q, count_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic [31:0] seq_pc;
   logic [31:0] next_pc;

   assign seq_pc = pc_q + 32'd4;

   // Next-PC selection using the control unit's pc_src encoding; jalr clears bit 0
   always_comb begin
      next_pc = seq_pc;
      case (pc_src)
         2'b00:   next_pc = seq_pc;
         2'b01:   next_pc = branch_taken ? branch_target : seq_pc;
         2'b10:   next_pc = jal_target;
         default: next_pc = jalr_target & 32'hFFFF_FFFE;
      endcase
   end

   // Fetch sequencing; output flags are derived from the next state so they are registered
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      count_d = count_q;
      case (state_q)
         S_RST:   state_d = S_FETCH;
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (retire) begin
               count_d = count_q + 32'd1;
               if (next_pc[1]) begin
                  state_d = S_FAULT;
               end else begin
                  pc_d    = next_pc;
                  state_d = S_FETCH;
               end
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_RST;
      endcase
      req_d   = (state_d == S_FETCH);
      valid_d = (state_d == S_EXEC);
      fault_d = (state_d == S_FAULT);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RST;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         count_q <= 32'd0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         count_q <= count_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign imem_req      = req_q;
   assign imem_addr     = pc_q;
   assign instr_valid   = valid_q;
   assign instr         = instr_q;
   assign opcode        = instr_q[6:0];
   assign pc            = pc_q;
   assign pc_plus4      = seq_pc;
   assign fetch_fault   = fault_q;
   assign retired_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit against a transaction-level model
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire = 1'b0;
   logic [1:0]  pc_src = 2'b00;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic [31:0] jal_target = 32'h0;
   logic [31:0] jalr_target = 32'h0;
   logic        fetch_fault;
   logic [31:0] retired_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] model_pc;
   logic [31:0] model_cnt;
   logic [31:0] model_instr;
   bit          model_fault;

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .opcode        (opcode),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .retire        (retire),
      .pc_src        (pc_src),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jal_target    (jal_target),
      .jalr_target   (jalr_target),
      .fetch_fault   (fetch_fault),
      .retired_count (retired_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] src,
                                              input logic taken, input logic [31:0] bt,
                                              input logic [31:0] jt, input logic [31:0] jrt);
      logic [31:0] r;
      case (src)
         2'd0:    r = cur + 32'd4;
         2'd1:    r = taken ? bt : cur + 32'd4;
         2'd2:    r = jt;
         default: r = {jrt[31:1], 1'b0};
      endcase
      return r;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
      check({tag, "_instr"}, instr, 32'h0000_0013);
      check({tag, "_opcode"}, {25'd0, opcode}, 32'h13);
      check({tag, "_pc"}, pc, 32'h0);
      check({tag, "_pc4"}, pc_plus4, 32'h4);
      check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
      check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
      check({tag, "_count"}, retired_count, 32'd0);
   endtask

   task automatic model_reset();
      model_pc    = 32'h0;
      model_cnt   = 32'h0;
      model_instr = 32'h0000_0013;
      model_fault = 0;
   endtask

   // Called at a negedge; leaves rst_n released at a negedge
   task automatic do_reset();
      rst_n = 1'b0;
      retire = 1'b0;
      imem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      model_reset();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", {31'd0, imem_req}, 32'd1);
   endtask

   // One fetch: respond dly cycles into WAIT, optionally asserting a spurious retire while waiting
   task automatic fetch_one(input logic [31:0] word, input int dly, input bit junk_retire);
      wait_req();
      check("imem_addr", imem_addr, model_pc);
      @(negedge clk);
      check("req_pulse", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < dly; i++) begin
         retire = junk_retire;
         pc_src = 2'b10;
         jal_target = 32'h0000_0800;
         @(negedge clk);
         check("wait_hold", {31'd0, instr_valid}, 32'd0);
         check("wait_count", retired_count, model_cnt);
      end
      retire = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      model_instr = word;
      check("exec_valid", {31'd0, instr_valid}, 32'd1);
      check("exec_instr", instr, word);
      check("exec_opcode", {25'd0, opcode}, {25'd0, word[6:0]});
      check("exec_pc", pc, model_pc);
      check("exec_pc4", pc_plus4, model_pc + 32'd4);
   endtask

   // rvalid while in EXEC must not recapture
   task automatic exec_noise();
      imem_rvalid = 1'b1;
      imem_rdata = ~model_instr;
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("noise_instr", instr, model_instr);
      check("noise_valid", {31'd0, instr_valid}, 32'd1);
   endtask

   task automatic retire_one(input logic [1:0] src, input logic taken, input logic [31:0] bt,
                             input logic [31:0] jt, input logic [31:0] jrt);
      logic [31:0] nxt;
      pc_src = src;
      branch_taken = taken;
      branch_target = bt;
      jal_target = jt;
      jalr_target = jrt;
      retire = 1'b1;
      @(negedge clk);
      retire = 1'b0;
      nxt = model_next(model_pc, src, taken, bt, jt, jrt);
      model_cnt = model_cnt + 32'd1;
      if (nxt[1]) model_fault = 1;
      else model_pc = nxt;
      check("ret_count", retired_count, model_cnt);
      check("ret_fault", {31'd0, fetch_fault}, {31'd0, model_fault});
      if (model_fault) begin
         check("fault_valid", {31'd0, instr_valid}, 32'd0);
         check("fault_pc", pc, model_pc);
         for (int i = 0; i < 5; i++) begin
            check("fault_noreq", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
         end
         check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
      end
   endtask

   initial begin
      logic [1:0]  src;
      logic [31:0] bt, jt, jrt;
      model_reset();
      @(negedge clk);
      do_reset();

      // Basic fetch of addi x1,x0,5 with rvalid one cycle after the request
      fetch_one(32'h0050_0093, 0, 0);
      retire_one(2'b01, 1'b0, 32'h40, 32'h0, 32'h0);
      check("br_nt_addr", imem_addr, 32'h4);
      fetch_one(32'h0000_0013, 0, 0);
      retire_one(2'b01, 1'b1, 32'h40, 32'h0, 32'h0);
      check("br_t_addr", imem_addr, 32'h40);
      check("count_two", retired_count, 32'd2);

      // jalr with bit0 set is masked; then a misaligned jalr faults
      fetch_one(32'h0000_8067, 0, 0);
      retire_one(2'b11, 1'b0, 32'h0, 32'h0, 32'h0000_0201);
      fetch_one(32'h0000_8067, 1, 0);
      retire_one(2'b11, 1'b0, 32'h0, 32'h0, 32'h0000_0103);
      do_reset();

      // pc wraps from 0xFFFF_FFFC to 0
      fetch_one(32'h0000_006F, 0, 0);
      retire_one(2'b10, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0);
      fetch_one(32'h0000_0013, 0, 0);
      check("wrap_pc4", pc_plus4, 32'h0);
      retire_one(2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);

      // Long wait with spurious retire, then rvalid noise in EXEC
      fetch_one(32'h1234_5693, 10, 1);
      exec_noise();
      retire_one(2'b00, 1'b0, 32'h0, 32'h0, 32'h0);

      // Reset asserted during WAIT
      wait_req();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("rst_wait");
      model_reset();
      rst_n = 1'b1;
      fetch_one(32'h0000_0013, 0, 0);
      retire_one(2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
      fetch_one(32'h0000_0013, 0, 0);

      // Reset coincident with retire in EXEC: reset wins
      rst_n = 1'b0;
      retire = 1'b1;
      pc_src = 2'b00;
      @(negedge clk);
      retire = 1'b0;
      check_reset_vals("rst_retire");
      model_reset();
      rst_n = 1'b1;

      // Randomized instruction stream against the model
      for (int k = 0; k < 150; k++) begin
         fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) exec_noise();
         src = 2'($urandom_range(0, 3));
         bt  = $urandom & 32'hFFFF_FFFC;
         jt  = $urandom & 32'hFFFF_FFFC;
         jrt = ($urandom & 32'hFFFF_FFFC) | {31'd0, 1'($urandom_range(0, 1))};
         if ($urandom_range(0, 9) == 0) begin
            bt  = bt | 32'h2;
            jt  = jt | 32'h2;
            jrt = jrt | 32'h2;
         end
         retire_one(src, 1'($urandom_range(0, 1)), bt, jt, jrt);
         if (model_fault) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
